// File: rtl/data_mem_pkg.sv
// Shared encodings for the data memory: access-size codes, loader FSM states
// and the alignment rule used by the core port.
package data_mem_pkg;

   localparam int MEMORY_MODE_WIDTH = 2;

   localparam logic [MEMORY_MODE_WIDTH-1:0] MEM_MODE_BYTE = 2'b00;
   localparam logic [MEMORY_MODE_WIDTH-1:0] MEM_MODE_HALF = 2'b01;
   localparam logic [MEMORY_MODE_WIDTH-1:0] MEM_MODE_WORD = 2'b10;

   typedef enum logic [1:0] {
      LD_IDLE = 2'b00,
      LD_LOAD = 2'b01,
      LD_DONE = 2'b10
   } ld_state_t;

   // Mode 2'b11 falls into the word rule.
   function automatic logic is_misaligned(input logic [MEMORY_MODE_WIDTH-1:0] mode,
                                          input logic [1:0] lane);
      logic mis;
      case (mode)
         MEM_MODE_BYTE: mis = 1'b0;
         MEM_MODE_HALF: mis = lane[0];
         default:       mis = (lane != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/data_mem_if.sv
// Core D_MEM port and byte-stream loader port of the data memory.
interface data_mem_if
   import data_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]        addr;
   logic [WORD_WIDTH-1:0]        dataIn;
   logic                         memRead;
   logic                         memWrite;
   logic [MEMORY_MODE_WIDTH-1:0] memMode;
   logic [WORD_WIDTH-1:0]        dataOut;
   logic                         misaligned;

   logic                         ld_start;
   logic [7:0]                   ld_byte;
   logic                         ld_valid;
   logic                         ld_last;
   logic                         ld_ready;
   logic                         busy;
   logic                         ld_done;

   modport master (
      output addr, dataIn, memRead, memWrite, memMode,
      output ld_start, ld_byte, ld_valid, ld_last,
      input  dataOut, misaligned, ld_ready, busy, ld_done
   );

   modport slave (
      input  addr, dataIn, memRead, memWrite, memMode,
      input  ld_start, ld_byte, ld_valid, ld_last,
      output dataOut, misaligned, ld_ready, busy, ld_done
   );

endinterface

// File: rtl/dmem_byte_loader.sv
// Preload engine: packs a valid/ready byte stream little-endian into words and
// emits one word write per 4 bytes (or per final partial word).
module dmem_byte_loader
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_start,
   input  logic [7:0]       ld_byte,
   input  logic             ld_valid,
   input  logic             ld_last,
   output logic             ld_ready,
   output logic             busy,
   output logic             ld_done,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [31:0]      wr_data
);

   ld_state_t        state_q, state_d;
   logic [1:0]       byte_cnt_q;
   logic [3:0][7:0]  pack_q;
   logic [3:0][7:0]  merged;
   logic [IDX_W-1:0] ptr_q;
   logic             accept;

   assign accept = (state_q == LD_LOAD) && ld_valid;

   // Lanes above byte_cnt stay zero because pack_q is cleared after every word write.
   always_comb begin
      merged             = pack_q;
      merged[byte_cnt_q] = ld_byte;
   end

   assign wr_en   = accept && ((byte_cnt_q == 2'd3) || ld_last);
   assign wr_idx  = ptr_q;
   assign wr_data = merged;

   always_comb begin
      state_d  = state_q;
      ld_ready = 1'b0;
      busy     = 1'b0;
      ld_done  = 1'b0;
      case (state_q)
         LD_IDLE: if (ld_start) state_d = LD_LOAD;
         LD_LOAD: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
            if (accept && ld_last) state_d = LD_DONE;
         end
         LD_DONE: begin
            busy    = 1'b1;
            ld_done = 1'b1;
            state_d = LD_IDLE;
         end
         default: state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= LD_IDLE;
         byte_cnt_q <= 2'd0;
         pack_q     <= '0;
         ptr_q      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == LD_IDLE && ld_start) begin
            byte_cnt_q <= 2'd0;
            pack_q     <= '0;
            ptr_q      <= '0;
         end else if (accept) begin
            if (wr_en) begin
               byte_cnt_q <= 2'd0;
               pack_q     <= '0;
               ptr_q      <= ptr_q + IDX_W'(1);
            end else begin
               byte_cnt_q <= byte_cnt_q + 2'd1;
               pack_q     <= merged;
            end
         end
      end
   end

endmodule

// File: rtl/data_mem.sv
// Synchronous byte-lane data memory with sign-extending one-cycle loads,
// misalignment flagging and a byte-stream preload port.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_WIDTH  = 32,
   parameter int WORD_WIDTH  = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   data_mem_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [3:0][7:0] mem [DEPTH_WORDS];

   logic                 busy;
   logic                 ld_wr_en;
   logic [IDX_W-1:0]     ld_wr_idx;
   logic [31:0]          ld_wr_data;

   logic [IDX_W-1:0]     idx_p0;
   logic [1:0]           lane_p0;
   logic [1:0]           mode_p0;
   logic                 mis_p0;
   logic                 rd_vld_p0;
   logic                 wr_vld_p0;
   logic [3:0]           be_p0;
   logic [3:0][7:0]      wdat_p0;

   logic [WORD_WIDTH-1:0] dout_p1;
   logic                  mis_p1;

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.addr[ADDR_WIDTH-1:IDX_W+2];

   function automatic logic [31:0] load_format(input logic [3:0][7:0] w,
                                               input logic [1:0]      lane,
                                               input logic [1:0]      mode);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] r;
      b = w[lane];
      h = lane[1] ? w[3:2] : w[1:0];
      case (mode)
         MEM_MODE_BYTE: r = 32'(b);
         MEM_MODE_HALF: r = 32'(h);
         default:       r = w;
      endcase
      return r;
   endfunction

   dmem_byte_loader #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_loader (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_start (bus.ld_start),
      .ld_byte  (bus.ld_byte),
      .ld_valid (bus.ld_valid),
      .ld_last  (bus.ld_last),
      .ld_ready (bus.ld_ready),
      .busy     (busy),
      .ld_done  (bus.ld_done),
      .wr_en    (ld_wr_en),
      .wr_idx   (ld_wr_idx),
      .wr_data  (ld_wr_data)
   );

   assign bus.busy = busy;

   // p0: core request decode
   assign idx_p0    = bus.addr[2 +: IDX_W];
   assign lane_p0   = bus.addr[1:0];
   assign mode_p0   = bus.memMode;
   assign mis_p0    = is_misaligned(mode_p0, lane_p0);
   assign rd_vld_p0 = bus.memRead  && !mis_p0 && !busy;
   assign wr_vld_p0 = bus.memWrite && !mis_p0 && !busy;

   always_comb begin
      be_p0   = 4'b1111;
      wdat_p0 = bus.dataIn[31:0];
      case (mode_p0)
         MEM_MODE_BYTE: begin
            be_p0   = 4'b0001 << lane_p0;
            wdat_p0 = {4{bus.dataIn[7:0]}};
         end
         MEM_MODE_HALF: begin
            be_p0   = lane_p0[1] ? 4'b1100 : 4'b0011;
            wdat_p0 = {2{bus.dataIn[15:0]}};
         end
         default: ;
      endcase
   end

   // Loader and core stores never overlap: core stores are gated off while busy.
   always_ff @(posedge clk) begin
      if (ld_wr_en) begin
         mem[ld_wr_idx] <= ld_wr_data;
      end else if (wr_vld_p0) begin
         for (int i = 0; i < 4; i++) begin
            if (be_p0[i]) mem[idx_p0][i] <= wdat_p0[i];
         end
      end
   end

   // p1: registered load result, read-first against a same-cycle store
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_p1 <= '0;
         mis_p1  <= 1'b0;
      end else begin
         mis_p1 <= !busy && (bus.memRead || bus.memWrite) && mis_p0;
         if (bus.memRead) begin
            dout_p1 <= rd_vld_p0 ? load_format(mem[idx_p0], lane_p0, mode_p0) : '0;
         end
      end
   end

   assign bus.dataOut    = dout_p1;
   assign bus.misaligned = mis_p1;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: core stores/loads, alignment, read-first,
// aliasing, preload and reset during preload.
module tb_data_mem;
   import data_mem_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;

   data_mem_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

   data_mem #(.DEPTH_WORDS(1024), .ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic core_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
      bus.addr = a; bus.dataIn = d; bus.memMode = m; bus.memWrite = 1'b1;
      tick();
      bus.memWrite = 1'b0;
   endtask

   task automatic core_read(input logic [31:0] a, input logic [1:0] m);
      bus.addr = a; bus.memMode = m; bus.memRead = 1'b1;
      tick();
      bus.memRead = 1'b0;
   endtask

   task automatic ld_begin();
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
   endtask

   task automatic ld_send(input logic [7:0] b, input logic last);
      bus.ld_byte = b; bus.ld_last = last; bus.ld_valid = 1'b1;
      tick();
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (bus.dataOut !== 32'h0) begin fails++; $display("FAIL reset_dataOut got=%h exp=%h", bus.dataOut, 32'h0); end
      checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL reset_misaligned got=%b exp=0", bus.misaligned); end
      checks++; if (bus.ld_ready !== 1'b0) begin fails++; $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.ld_done !== 1'b0) begin fails++; $display("FAIL reset_ld_done got=%b exp=0", bus.ld_done); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_word();
      core_write(32'h100, 32'hDEADBEEF, MEM_MODE_WORD);
      core_read(32'h100, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load got=%h exp=%h", bus.dataOut, 32'hDEADBEEF); end
      checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL word_mis got=%b exp=0", bus.misaligned); end
   endtask

   task automatic test_byte_half();
      core_write(32'h103, 32'h12345680, MEM_MODE_BYTE);
      core_read(32'h103, MEM_MODE_BYTE);
      checks++; if (bus.dataOut !== 32'hFFFFFF80) begin fails++; $display("FAIL byte_103 got=%h exp=%h", bus.dataOut, 32'hFFFFFF80); end
      core_read(32'h100, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h80ADBEEF) begin fails++; $display("FAIL word_after_byte got=%h exp=%h", bus.dataOut, 32'h80ADBEEF); end
      core_read(32'h102, MEM_MODE_HALF);
      checks++; if (bus.dataOut !== 32'hFFFF80AD) begin fails++; $display("FAIL half_102 got=%h exp=%h", bus.dataOut, 32'hFFFF80AD); end
      core_read(32'h100, MEM_MODE_HALF);
      checks++; if (bus.dataOut !== 32'hFFFFBEEF) begin fails++; $display("FAIL half_100 got=%h exp=%h", bus.dataOut, 32'hFFFFBEEF); end
      core_read(32'h101, MEM_MODE_BYTE);
      checks++; if (bus.dataOut !== 32'hFFFFFFBE) begin fails++; $display("FAIL byte_101 got=%h exp=%h", bus.dataOut, 32'hFFFFFFBE); end
      core_read(32'h100, 2'b11);
      checks++; if (bus.dataOut !== 32'h80ADBEEF) begin fails++; $display("FAIL mode11_word got=%h exp=%h", bus.dataOut, 32'h80ADBEEF); end
      tick();
      checks++; if (bus.dataOut !== 32'h80ADBEEF) begin fails++; $display("FAIL hold_no_read got=%h exp=%h", bus.dataOut, 32'h80ADBEEF); end
   endtask

   task automatic test_misaligned();
      core_write(32'h101, 32'h0000AAAA, MEM_MODE_HALF);
      checks++; if (bus.misaligned !== 1'b1) begin fails++; $display("FAIL mis_half_store got=%b exp=1", bus.misaligned); end
      core_read(32'h100, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h80ADBEEF) begin fails++; $display("FAIL mis_store_unchanged got=%h exp=%h", bus.dataOut, 32'h80ADBEEF); end
      checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL mis_clear got=%b exp=0", bus.misaligned); end
      core_read(32'h102, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h0) begin fails++; $display("FAIL mis_word_data got=%h exp=%h", bus.dataOut, 32'h0); end
      checks++; if (bus.misaligned !== 1'b1) begin fails++; $display("FAIL mis_word_flag got=%b exp=1", bus.misaligned); end
   endtask

   task automatic test_read_first();
      core_write(32'h200, 32'h11111111, MEM_MODE_WORD);
      bus.addr = 32'h200; bus.dataIn = 32'h22222222; bus.memMode = MEM_MODE_WORD;
      bus.memRead = 1'b1; bus.memWrite = 1'b1;
      tick();
      bus.memRead = 1'b0; bus.memWrite = 1'b0;
      checks++; if (bus.dataOut !== 32'h11111111) begin fails++; $display("FAIL rw_old got=%h exp=%h", bus.dataOut, 32'h11111111); end
      core_read(32'h200, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h22222222) begin fails++; $display("FAIL rw_new got=%h exp=%h", bus.dataOut, 32'h22222222); end
      core_read(32'h201, MEM_MODE_BYTE);
      checks++; if (bus.dataOut !== 32'h00000022) begin fails++; $display("FAIL byte_pos got=%h exp=%h", bus.dataOut, 32'h00000022); end
   endtask

   task automatic test_alias();
      core_read(32'h1100, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h80ADBEEF) begin fails++; $display("FAIL alias_wrap got=%h exp=%h", bus.dataOut, 32'h80ADBEEF); end
   endtask

   task automatic test_preload();
      bus.ld_byte = 8'hEE; bus.ld_valid = 1'b1;
      tick();
      bus.ld_valid = 1'b0;
      checks++; if (bus.ld_ready !== 1'b0) begin fails++; $display("FAIL idle_ready got=%b exp=0", bus.ld_ready); end
      ld_begin();
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL load_busy got=%b exp=1", bus.busy); end
      checks++; if (bus.ld_ready !== 1'b1) begin fails++; $display("FAIL load_ready got=%b exp=1", bus.ld_ready); end
      ld_send(8'h01, 1'b0);
      ld_send(8'h02, 1'b0);
      core_write(32'h100, 32'hFFFFFFFF, MEM_MODE_WORD);
      core_read(32'h100, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h0) begin fails++; $display("FAIL busy_load_zero got=%h exp=%h", bus.dataOut, 32'h0); end
      ld_send(8'h03, 1'b0);
      ld_send(8'h04, 1'b0);
      ld_send(8'h05, 1'b1);
      checks++; if (bus.ld_done !== 1'b1) begin fails++; $display("FAIL done_pulse got=%b exp=1", bus.ld_done); end
      checks++; if (bus.ld_ready !== 1'b0) begin fails++; $display("FAIL done_ready got=%b exp=0", bus.ld_ready); end
      tick();
      checks++; if (bus.ld_done !== 1'b0) begin fails++; $display("FAIL done_one_cycle got=%b exp=0", bus.ld_done); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
      core_read(32'h0, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h04030201) begin fails++; $display("FAIL preload_w0 got=%h exp=%h", bus.dataOut, 32'h04030201); end
      core_read(32'h100, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h80ADBEEF) begin fails++; $display("FAIL busy_store_dropped got=%h exp=%h", bus.dataOut, 32'h80ADBEEF); end
      core_read(32'h4, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h00000005) begin fails++; $display("FAIL preload_w1 got=%h exp=%h", bus.dataOut, 32'h00000005); end
   endtask

   task automatic test_reset_mid_load();
      ld_begin();
      ld_send(8'hA1, 1'b0);
      ld_send(8'hA2, 1'b0);
      rst_n = 1'b0;
      #2;
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.ld_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_ready got=%b exp=0", bus.ld_ready); end
      checks++; if (bus.dataOut !== 32'h0) begin fails++; $display("FAIL rst_mid_dataOut got=%h exp=%h", bus.dataOut, 32'h0); end
      tick();
      rst_n = 1'b1;
      tick();
      ld_begin();
      ld_send(8'hB1, 1'b0);
      ld_send(8'hB2, 1'b0);
      ld_send(8'hB3, 1'b0);
      ld_send(8'hB4, 1'b1);
      checks++; if (bus.ld_done !== 1'b1) begin fails++; $display("FAIL restart_done got=%b exp=1", bus.ld_done); end
      tick();
      core_read(32'h0, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'hB4B3B2B1) begin fails++; $display("FAIL restart_w0 got=%h exp=%h", bus.dataOut, 32'hB4B3B2B1); end
      core_read(32'h4, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h00000005) begin fails++; $display("FAIL retained_w1 got=%h exp=%h", bus.dataOut, 32'h00000005); end
      core_read(32'h200, MEM_MODE_WORD);
      checks++; if (bus.dataOut !== 32'h22222222) begin fails++; $display("FAIL retained_200 got=%h exp=%h", bus.dataOut, 32'h22222222); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      bus.addr = '0; bus.dataIn = '0; bus.memRead = 1'b0; bus.memWrite = 1'b0;
      bus.memMode = MEM_MODE_WORD;
      bus.ld_start = 1'b0; bus.ld_byte = 8'h00; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      test_reset();
      test_word();
      test_byte_half();
      test_misaligned();
      test_read_first();
      test_alias();
      test_preload();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
